// File: rtl/gmii_tx_sched.sv
// Gigabit Ethernet transmit scheduler: round-robin between two frame sources,
// emits preamble/SFD, streams and pads payload, then reserves FCS tail and IFG.
module gmii_tx_sched #(
  parameter int PRE_LEN = 7,
  parameter int IFG_LEN = 12,
  parameter int MIN_LEN = 60,
  parameter int MAX_LEN = 1514
) (
  input  logic        sclk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [10:0] len0,
  input  logic [10:0] len1,
  input  logic        err0,
  input  logic        err1,
  input  logic [7:0]  data0,
  input  logic [7:0]  data1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rd0,
  output logic        rd1,
  output logic        dsin_o,
  output logic [7:0]  din_o,
  output logic        pre_flag_o,
  output logic        crc_err_en_o,
  output logic        busy,
  output logic        tx_done
);

  localparam logic [10:0] PreLast  = 11'(PRE_LEN - 1);
  localparam logic [10:0] IfgLast  = 11'(IFG_LEN - 1);
  localparam logic [10:0] TailLast = 11'd3;
  localparam logic [10:0] MinLen   = 11'(MIN_LEN);
  localparam logic [10:0] MaxLen   = 11'(MAX_LEN);

  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, TAIL, IFG} stateT;

  stateT       state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic        src_q;
  logic        ptr_q;
  logic [10:0] effLen_q;
  logic [10:0] rdLen_q;

  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic        rd0_q, rd0_d;
  logic        rd1_q, rd1_d;
  logic        dsin_q, dsin_d;
  logic [7:0]  din_q, din_d;
  logic        pre_q, pre_d;
  logic        crcErr_q, crcErr_d;
  logic        txDone_q, txDone_d;

  logic        grant;
  logic        winner;
  logic [10:0] winLen;
  logic        winErr;
  logic [10:0] clampLen;
  logic [10:0] padLen;
  logic        rdAct;

  // On a tie the pointer decides; otherwise the only requester wins.
  always_comb begin
    grant    = (state_q == IDLE) && (req0 || req1);
    winner   = (req0 && req1) ? ptr_q : req1;
    winLen   = winner ? len1 : len0;
    winErr   = winner ? err1 : err0;
    clampLen = (winLen > MaxLen) ? MaxLen : winLen;
    padLen   = (clampLen < MinLen) ? MinLen : clampLen;
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      src_q    <= 1'b0;
      ptr_q    <= 1'b0;
      effLen_q <= '0;
      rdLen_q  <= '0;
    end else if (grant) begin
      src_q    <= winner;
      ptr_q    <= ~winner;
      effLen_q <= padLen;
      rdLen_q  <= clampLen;
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 11'd1;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (grant) state_d = PRE;
      end
      PRE: begin
        if (cnt_q == PreLast) begin
          state_d = SFD;
          cnt_d   = '0;
        end
      end
      SFD: begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: begin
        if (cnt_q == effLen_q - 11'd1) begin
          state_d = TAIL;
          cnt_d   = '0;
        end
      end
      TAIL: begin
        if (cnt_q == TailLast) begin
          state_d = IFG;
          cnt_d   = '0;
        end
      end
      IFG: begin
        if (cnt_q == IfgLast) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are computed from the next state so the registered values line
  // up with the state the FSM is in; din carries the byte read on the last rd.
  always_comb begin
    gnt0_d   = grant && !winner;
    gnt1_d   = grant && winner;
    dsin_d   = (state_d == PRE) || (state_d == SFD) || (state_d == DATA);
    pre_d    = (state_d == PRE) || (state_d == SFD);
    crcErr_d = grant ? winErr : crcErr_q;
    txDone_d = (state_q == TAIL) && (state_d == IFG);
    rdAct    = 1'b0;
    din_d    = 8'h00;
    case (state_d)
      PRE: din_d = 8'h55;
      SFD: begin
        din_d = 8'hD5;
        rdAct = (rdLen_q != 11'd0);
      end
      DATA: begin
        rdAct = ({1'b0, cnt_d} + 12'd1) < {1'b0, rdLen_q};
        if (cnt_d < rdLen_q) din_d = src_q ? data1 : data0;
      end
      default: din_d = 8'h00;
    endcase
    rd0_d = rdAct && !src_q;
    rd1_d = rdAct && src_q;
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      rd0_q    <= 1'b0;
      rd1_q    <= 1'b0;
      dsin_q   <= 1'b0;
      din_q    <= 8'h00;
      pre_q    <= 1'b0;
      crcErr_q <= 1'b0;
      txDone_q <= 1'b0;
    end else begin
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      rd0_q    <= rd0_d;
      rd1_q    <= rd1_d;
      dsin_q   <= dsin_d;
      din_q    <= din_d;
      pre_q    <= pre_d;
      crcErr_q <= crcErr_d;
      txDone_q <= txDone_d;
    end
  end

  assign gnt0         = gnt0_q;
  assign gnt1         = gnt1_q;
  assign rd0          = rd0_q;
  assign rd1          = rd1_q;
  assign dsin_o       = dsin_q;
  assign din_o        = din_q;
  assign pre_flag_o   = pre_q;
  assign crc_err_en_o = crcErr_q;
  assign tx_done      = txDone_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: doc/gmii_tx_sched.md
# gmii_tx_sched

Transmit frame scheduler that sits directly upstream of the CRC-append stage on the Gigabit Ethernet transmit path. It arbitrates round-robin between two frame sources and generates the 7-byte preamble and the SFD. It streams payload bytes, zero-pads short frames to the 60-byte minimum, and drives the CRC stage's data-strobe, data, preamble-flag and error-inject inputs. After each frame it reserves the 4-byte CRC tail and the 12-byte inter-frame gap before granting the next frame.

## Interface
- PRE_LEN, 7, number of 0x55 preamble bytes before the SFD
- IFG_LEN, 12, idle cycles after the CRC tail
- MIN_LEN, 60, minimum payload bytes before CRC; shorter frames are zero-padded
- MAX_LEN, 1514, maximum payload bytes; larger lengths are clamped
- sclk  in  1  clock
- rst  in  1  reset, synchronous, active-high; clock sclk
- req0 / req1  in  1  frame request from source 0/1; held high until the matching gnt
- len0 / len1  in  11  payload byte count of the source 0/1 frame; must be valid while req is high
- err0 / err1  in  1  corrupt-CRC request for the source 0/1 frame
- data0 / data1  in  8  show-ahead source data; valid whenever the matching rd is high
- gnt0 / gnt1  out  1  one-cycle grant pulse
- rd0 / rd1  out  1  read strobe; the source advances to the next byte after each rd cycle
- dsin_o  out  1  data strobe to the CRC stage
- din_o  out  8  byte to the CRC stage
- pre_flag_o  out  1  high on preamble and SFD bytes; these bytes are excluded from the CRC
- crc_err_en_o  out  1  0 = normal (inverted) FCS, 1 = corrupted FCS
- busy  out  1  high whenever the state is not IDLE
- tx_done  out  1  one-cycle pulse on the first IFG cycle

## Operation
- States: IDLE, PRE, SFD, DATA, TAIL, IFG.
- IDLE:
  - If any req is high, pick the winner by round-robin.
  - After reset, or when the pointer favours it, source 0 wins ties.
  - The pointer moves to the other source after each grant.
  - On grant, latch the winner, the effective length N = min(max(len, MIN_LEN), MAX_LEN), the readable count R = min(len, MAX_LEN) and the err bit.
  - Go to PRE.
- PRE:
  - Drive dsin_o=1, pre_flag_o=1, din_o=0x55 for PRE_LEN cycles.
  - The gnt pulse coincides with the first PRE cycle.
- SFD:
  - Drive one cycle with din_o=0xD5, dsin_o=1, pre_flag_o=1.
- DATA:
  - Drive N cycles with dsin_o=1 and pre_flag_o=0.
  - Byte k < R is the source data; byte k ≥ R is 0x00 (padding).
- TAIL:
  - Drive 4 cycles with dsin_o=0 and din_o=0x00. These cycles reserve the CRC stage's FCS output.
- IFG:
  - Drive IFG_LEN cycles with dsin_o=0, then return to IDLE.
- Read strobes:
  - rd of the granted source is high for exactly R cycles: the SFD cycle plus the first R−1 DATA cycles.
  - data sampled at the end of each rd cycle appears on din_o in the following cycle.
  - The non-granted rd stays 0.
- len=0: produces a 60-byte all-zero frame with no rd cycles.
- crc_err_en_o takes the latched err value from the first PRE cycle and holds until the next grant. This covers the CRC stage's one-cycle output lag.
- req lines are ignored outside IDLE. A req dropped before it is granted is not served.

## Timing
- Reset values: gnt0=gnt1=rd0=rd1=0, dsin_o=0, din_o=0x00, pre_flag_o=0, crc_err_en_o=0, busy=0, tx_done=0. The state returns to IDLE and the round-robin pointer favours source 0.
- dsin_o, din_o and pre_flag_o are registered.
- Request latency: a req first seen high in an IDLE cycle T gives gnt, busy and the first preamble byte on din_o at T+1.
- Frame length: 8 + N cycles of dsin_o=1, then 4 TAIL + IFG_LEN idle cycles.
- Minimum grant-to-grant spacing: 8 + N + 16 + 1 cycles.
- tx_done pulses at cycle 8 + N + 4 after gnt.
- Reset mid-frame: all outputs return to their reset values on the next edge. No further rd is issued, and the CRC stage sees dsin_o fall.
- Both requests high in the same cycle as a reset: reset wins; arbitration starts on the next cycle.

## Test plan
- Single frame, source 0, len=64, err0=0, bytes 0x00..0x3F:
  - din_o shows 7×0x55, 0xD5, 0x00..0x3F; rd0 high for 64 cycles.
  - The CRC stage output FCS matches the software CRC-32.
  - tx_done fires 76 cycles after gnt0.
- Short frame, len=10:
  - 10 source bytes then 50×0x00; rd high for exactly 10 cycles.
  - dsin_o high for 68 cycles.
- Both reqs held high continuously, len=60 each:
  - Grants alternate 0,1,0,1, starting with source 0.
  - Spacing between gnt pulses is exactly 85 cycles.
  - The idle gap after each 4-byte FCS is exactly 12 cycles.
- err1=1, len=100:
  - crc_err_en_o=1 from the first PRE cycle through the end of IFG.
  - The CRC stage emits the non-inverted FCS and the receiver checker flags the frame.
- Special lengths:
  - len=0 gives 60 zero bytes and no rd cycles.
  - len=2000 is clamped to 1514 rd cycles and a 1514-byte frame.
- Reset asserted at DATA byte 20:
  - The next cycle has dsin_o=0, rd0=0, busy=0.
  - A new req1 is then granted at the very next IDLE cycle with a clean preamble.
